// File: rtl/voice_mixer_pwm_pkg.sv
// Shared definitions for the voice mixer / PWM DAC slice: FSM state
// encoding, sample midpoint and the dither LFSR constants and step helper.
package voice_mixer_pwm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SCALE = 2'd2,
        ST_HOLD  = 2'd3
    } mix_state_e;

    localparam int                DEF_SAMPLE_W = 8;
    localparam logic [7:0]        SAMPLE_MID   = 8'h80;

    // Galois LFSR used only when dithering is compiled in.
    localparam logic [15:0]       LFSR_TAPS    = 16'hB400;
    localparam logic [15:0]       LFSR_SEED    = 16'hACE1;

    // One right-shifting Galois step.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/voice_mixer_pwm_dac.sv
// PWM DAC: free-running period counter, double-buffered duty register and a
// registered comparator. A new duty is loaded on the wrap cycle so it takes
// effect exactly at the next count of zero.
module voice_mixer_pwm_dac #(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             duty_load,
    input  logic [PWM_W-1:0] duty_in,
    output logic [PWM_W-1:0] pwm_cnt,
    output logic             wrap,
    output logic             pwm_out
);

    localparam logic [PWM_W-1:0] DUTY_MID = {1'b1, {(PWM_W-1){1'b0}}};

    logic [PWM_W-1:0] cnt_q, cnt_d;
    logic [PWM_W-1:0] duty_q, duty_d;
    logic             pwm_q, pwm_d;

    // Next counter/duty values; the comparator looks at the next values so
    // pwm_out lines up with the count it belongs to.
    always_comb begin
        cnt_d  = cnt_q + PWM_W'(1);
        duty_d = duty_load ? duty_in : duty_q;
        pwm_d  = (cnt_d < duty_d);
    end

    // Counter, duty and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            duty_q <= DUTY_MID;
            pwm_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm_cnt = cnt_q;
    assign wrap    = (cnt_q == '1);
    assign pwm_out = pwm_q;

endmodule

// File: rtl/voice_mixer_pwm.sv
// Voice mixer with PWM output. Once per PWM period it sums the active voices
// (offset-binary in, signed inside), attenuates, applies volume/8, saturates
// to one sample and hands it to the PWM DAC at the next period boundary.
// Optional build macro: MIXER_DITHER_EN adds LFSR rounding dither before the
// attenuation shift; without it the shift truncates and no LFSR exists.
module voice_mixer_pwm
    import voice_mixer_pwm_pkg::*;
#(
    parameter int NUM_VOICES  = 8,
    parameter int SAMPLE_W    = 8,
    parameter int PWM_W       = 8,
    parameter int ATTEN_SHIFT = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_VOICES-1:0]          voice_active,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
    input  logic [3:0]                     volume,
    output logic [SAMPLE_W-1:0]            mix_out,
    output logic                           sample_strobe,
    output logic                           clip,
    output logic                           pwm_out,
    output logic [1:0]                     dbg_state
);

    localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int ACC_W  = SAMPLE_W + $clog2(NUM_VOICES) + 1;
    localparam int PROD_W = ACC_W + 5;

    localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [SAMPLE_W-1:0]      MIX_MID  = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic signed [PROD_W-1:0] SAT_MAX  = PROD_W'((1 << (SAMPLE_W-1)) - 1);
    localparam logic signed [PROD_W-1:0] SAT_MIN  = PROD_W'(-(1 << (SAMPLE_W-1)));

    mix_state_e state_q, state_d;

    logic [NUM_VOICES-1:0]     active_q, active_d;
    logic [3:0]                vol_q, vol_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [SAMPLE_W-1:0]       mix_q, mix_d;
    logic                      clip_q, clip_d;

    logic [PWM_W-1:0]          pwm_cnt;
    logic                      pwm_wrap;
    logic                      cnt_zero;
    logic                      duty_load;
    logic                      strobe_c;

    logic [SAMPLE_W-1:0]        cur_sample;
    logic signed [SAMPLE_W-1:0] voice_s;
    logic signed [ACC_W-1:0]    term;
    logic signed [ACC_W-1:0]    dither_val;
    logic signed [ACC_W-1:0]    acc_dith;
    logic signed [ACC_W-1:0]    shifted;
    logic signed [PROD_W-1:0]   shifted_ext;
    logic signed [PROD_W-1:0]   vol_ext;
    logic signed [PROD_W-1:0]   prod;
    logic signed [PROD_W-1:0]   scaled;
    logic signed [SAMPLE_W-1:0] sat;
    logic                       sat_hit;

    assign cnt_zero = (pwm_cnt == '0);

    voice_mixer_pwm_dac #(
        .PWM_W (PWM_W)
    ) u_dac (
        .clk       (clk),
        .rst_n     (rst_n),
        .duty_load (duty_load),
        .duty_in   (mix_q),
        .pwm_cnt   (pwm_cnt),
        .wrap      (pwm_wrap),
        .pwm_out   (pwm_out)
    );

`ifdef MIXER_DITHER_EN
    localparam logic [15:0] DITHER_MASK = 16'((1 << ATTEN_SHIFT) - 1);

    logic [15:0] lfsr_q, lfsr_d;

    // The LFSR advances once per mix, on the scale cycle that consumes it.
    always_comb begin
        lfsr_d     = (state_q == ST_SCALE) ? lfsr_step(lfsr_q) : lfsr_q;
        dither_val = ACC_W'(lfsr_q & DITHER_MASK);
    end

    // Dither LFSR register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= lfsr_d;
    end
`else
    assign dither_val = '0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: start at the period start, one voice per cycle, one
    // scale cycle, then hold until the period wraps.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cnt_zero)            state_d = ST_ACCUM;
            ST_ACCUM: if (idx_q == LAST_IDX)   state_d = ST_SCALE;
            ST_SCALE:                          state_d = ST_HOLD;
            ST_HOLD:  if (pwm_wrap)            state_d = ST_IDLE;
            default:                           state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: strobe during the scale cycle (mix_out updates at its end),
    // duty handoff on the last cycle of the period.
    always_comb begin
        strobe_c  = (state_q == ST_SCALE);
        duty_load = (state_q == ST_HOLD) && pwm_wrap;
        dbg_state = state_q;
    end

    // Mix arithmetic: per-voice signed term and the scale/saturate path.
    always_comb begin
        cur_sample  = voice_sample[idx_q*SAMPLE_W +: SAMPLE_W];
        // Offset binary to two's complement is an MSB flip.
        voice_s     = {~cur_sample[SAMPLE_W-1], cur_sample[SAMPLE_W-2:0]};
        if (active_q[idx_q]) term = {{(ACC_W-SAMPLE_W){voice_s[SAMPLE_W-1]}}, voice_s};
        else                 term = '0;

        acc_dith    = acc_q + dither_val;
        shifted     = acc_dith >>> ATTEN_SHIFT;
        shifted_ext = {{(PROD_W-ACC_W){shifted[ACC_W-1]}}, shifted};
        vol_ext     = {{(PROD_W-4){1'b0}}, vol_q};
        prod        = shifted_ext * vol_ext;
        scaled      = prod >>> 3;

        sat_hit = 1'b0;
        sat     = scaled[SAMPLE_W-1:0];
        if (scaled > SAT_MAX) begin
            sat     = SAT_MAX[SAMPLE_W-1:0];
            sat_hit = 1'b1;
        end else if (scaled < SAT_MIN) begin
            sat     = SAT_MIN[SAMPLE_W-1:0];
            sat_hit = 1'b1;
        end
    end

    // Datapath next values, gated by FSM state.
    always_comb begin
        active_d = active_q;
        vol_d    = vol_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        mix_d    = mix_q;
        clip_d   = clip_q;
        case (state_q)
            ST_IDLE: begin
                if (cnt_zero) begin
                    active_d = voice_active;
                    vol_d    = volume;
                    acc_d    = '0;
                    idx_d    = '0;
                end
            end
            ST_ACCUM: begin
                acc_d = acc_q + term;
                idx_d = idx_q + IDX_W'(1);
            end
            ST_SCALE: begin
                mix_d  = {~sat[SAMPLE_W-1], sat[SAMPLE_W-2:0]};
                clip_d = sat_hit;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= '0;
            vol_q    <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            mix_q    <= MIX_MID;
            clip_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            vol_q    <= vol_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            mix_q    <= mix_d;
            clip_q   <= clip_d;
        end
    end

    assign mix_out       = mix_q;
    assign clip          = clip_q;
    assign sample_strobe = strobe_c;

endmodule
